// File: rtl/udma_cfg_pkg.sv
// Shared types for the uDMA cfg-bus initiator: command op codes, the
// queued command record and the sequencing FSM states.
package udma_cfg_pkg;

  localparam int CFG_ADDR_W = 5;
  localparam int CFG_DATA_W = 32;

  typedef enum logic [1:0] {
    CFG_WR   = 2'd0,
    CFG_RD   = 2'd1,
    CFG_POLL = 2'd2
  } cfg_op_e;

  typedef struct packed {
    cfg_op_e                 op;
    logic [CFG_ADDR_W-1:0]   addr;
    logic [CFG_DATA_W-1:0]   data;
    logic [CFG_DATA_W-1:0]   mask;
  } cfg_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    RESP  = 2'd3
  } cfg_state_e;

  // Raw op code 3 is reserved and executes as a plain READ.
  function automatic cfg_op_e decode_op(input logic [1:0] raw);
    cfg_op_e op;
    case (raw)
      2'd0:    op = CFG_WR;
      2'd2:    op = CFG_POLL;
      default: op = CFG_RD;
    endcase
    return op;
  endfunction

  // A POLL attempt succeeds when every masked bit of the sample equals the expected value.
  function automatic logic poll_hit(input logic [CFG_DATA_W-1:0] sample,
                                    input logic [CFG_DATA_W-1:0] expected,
                                    input logic [CFG_DATA_W-1:0] mask);
    return ((sample ^ expected) & mask) == '0;
  endfunction

endpackage

// File: rtl/udma_cfg_cmd_fifo.sv
// Synchronous FIFO of cfg commands. A push while full is dropped even if a
// pop happens in the same cycle; otherwise push and pop both take effect.
module udma_cfg_cmd_fifo
  import udma_cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  cfg_cmd_t cmd_i,
  input  logic     pop_i,
  output cfg_cmd_t cmd_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  cfg_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (PTR_W+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cmd_o   = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= cmd_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udma_cfg_master.sv
// uDMA cfg-bus initiator: pops queued WRITE/READ/POLL commands, runs one cfg
// transaction at a time and returns exactly one response per command, in order.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid is held with its payload stable until that edge.
module udma_cfg_master
  import udma_cfg_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int POLL_MAX_TRIES = 16,
  parameter int POLL_GAP       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [CFG_ADDR_W-1:0] cmd_addr_i,
  input  logic [CFG_DATA_W-1:0] cmd_data_i,
  input  logic [CFG_DATA_W-1:0] cmd_mask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [CFG_DATA_W-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [CFG_DATA_W-1:0] cfg_data_o,
  output logic [CFG_ADDR_W-1:0] cfg_addr_o,
  output logic                  cfg_valid_o,
  output logic                  cfg_rwn_o,
  input  logic [CFG_DATA_W-1:0] cfg_data_i,
  input  logic                  cfg_ready_i,
  output logic                  busy_o,
  output cfg_state_e            dbg_state_o
);

  localparam int TRY_W = $clog2(POLL_MAX_TRIES + 1);
  localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

  cfg_state_e       state;
  cfg_op_e          cur_op;
  logic [CFG_DATA_W-1:0] cur_mask;
  logic [TRY_W-1:0] tries;
  logic [GAP_W-1:0] gap_cnt;

  cfg_cmd_t push_cmd;
  cfg_cmd_t head_cmd;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;

  // Normalise the incoming command so the reserved op is stored as READ.
  always_comb begin
    push_cmd      = '0;
    push_cmd.op   = decode_op(cmd_op_i);
    push_cmd.addr = cmd_addr_i;
    push_cmd.data = cmd_data_i;
    push_cmd.mask = cmd_mask_i;
  end

  assign cmd_ready_o = !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign busy_o      = (state != IDLE) || !fifo_empty;
  assign dbg_state_o = state;

  udma_cfg_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .cmd_i   (push_cmd),
    .pop_i   (fifo_pop),
    .cmd_o   (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Command sequencer: all cfg_* and rsp_* outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cur_op      <= CFG_RD;
      cur_mask    <= '0;
      tries       <= '0;
      gap_cnt     <= '0;
      cfg_valid_o <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      cfg_rwn_o   <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_op      <= head_cmd.op;
            cur_mask    <= head_cmd.mask;
            cfg_addr_o  <= head_cmd.addr;
            cfg_data_o  <= head_cmd.data;
            cfg_rwn_o   <= (head_cmd.op != CFG_WR);
            cfg_valid_o <= 1'b1;
            tries       <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_ready_i) begin
            cfg_valid_o <= 1'b0;
            case (cur_op)
              CFG_WR: begin
                rsp_data_o  <= '0;
                rsp_err_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                state       <= RESP;
              end
              CFG_POLL: begin
                if (poll_hit(cfg_data_i, cfg_data_o, cur_mask)) begin
                  rsp_data_o  <= cfg_data_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
                end else if (int'(tries) + 1 == POLL_MAX_TRIES) begin
                  rsp_data_o  <= cfg_data_i;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
                end else begin
                  tries   <= tries + TRY_W'(1);
                  gap_cnt <= '0;
                  state   <= GAP;
                end
              end
              default: begin
                rsp_data_o  <= cfg_data_i;
                rsp_err_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                state       <= RESP;
              end
            endcase
          end
        end
        GAP: begin
          // At least one idle cycle separates attempts, even with a zero gap.
          if (int'(gap_cnt) + 1 >= POLL_GAP) begin
            cfg_valid_o <= 1'b1;
            state       <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_cfg_master.sv
// Bench for udma_cfg_master: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the command flow.
module tb_udma_cfg_master;
  import udma_cfg_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_TRIES = 16;
  localparam int GAP_CYC   = 8;
  localparam int GAP_EFF   = (GAP_CYC == 0) ? 1 : GAP_CYC;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [31:0] cmd_mask_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;
  logic        busy_o;
  cfg_state_e  dbg_state;

  always #5 clk = ~clk;

  udma_cfg_master #(
    .CMD_DEPTH      (DEPTH),
    .POLL_MAX_TRIES (MAX_TRIES),
    .POLL_GAP       (GAP_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_mask_i  (cmd_mask_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .cfg_data_o  (cfg_data_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_valid_o (cfg_valid_o),
    .cfg_rwn_o   (cfg_rwn_o),
    .cfg_data_i  (cfg_data_i),
    .cfg_ready_i (cfg_ready_i),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- responder / rsp_ready control ----------------
  int          rdy_mode    = 0;   // 0 always, 1 random, 2 never, 3 low for first 3 valid cycles
  int          dat_mode    = 0;   // 0 const, 1 bit5 clears after N reads, 2 random, 3 addr tagged
  logic [31:0] dat_const   = 32'h0;
  int          clear_after = 0;
  int          rd_cnt      = 0;
  int          rd_base     = 0;
  int          vcnt        = 0;
  int          v_base      = 0;
  bit          rrdy_rand   = 1'b0;
  bit          rrdy_force  = 1'b1;

  initial begin
    logic [31:0] r;
    cfg_ready_i = 1'b0;
    cfg_data_i  = '0;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_valid_o && cfg_ready_i && cfg_rwn_o) rd_cnt++;
      if (cfg_valid_o) vcnt++;
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       cfg_ready_i = 1'b1;
        1:       cfg_ready_i = ($urandom_range(0, 3) != 0);
        2:       cfg_ready_i = 1'b0;
        default: cfg_ready_i = ((vcnt - v_base) >= 3);
      endcase
      case (dat_mode)
        0:       cfg_data_i = dat_const;
        1:       cfg_data_i = ((rd_cnt - rd_base) >= clear_after) ? 32'h0 : 32'h20;
        2: begin
          r = $urandom;
          r[2:0] = 3'($urandom_range(0, 7));
          cfg_data_i = r;
        end
        default: cfg_data_i = 32'hA5A5_0000 | {27'h0, cfg_addr_o};
      endcase
      rsp_ready_i = rrdy_rand ? ($urandom_range(0, 3) != 0) : rrdy_force;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    int          op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } mcmd_t;

  mcmd_t       mq[$];          // accepted, not yet started commands
  logic [32:0] exp_q[$];       // expected {err, data} of the response being presented
  mcmd_t       cur;
  bit          inflight   = 1'b0;
  bit          start_next = 1'b0;
  int          att        = 0;
  int          gap_left   = 0;

  int          hs_cnt = 0, rsp_cnt = 0, valid_hi_cnt = 0;
  int          push_cyc = 0, start_cyc = 0, last_hs_cyc = 0, rise_cyc = 0, rsp_rise_cyc = 0;
  logic [31:0] last_rsp_data = '0;
  logic        last_rsp_err  = 1'b0;
  bit          prev_valid = 1'b0, prev_rsp = 1'b0;

  initial begin
    bit          in_issue, in_gap, rsp_done, fin, err;
    logic [31:0] sample;
    int          qsize;
    forever begin
      @(negedge clk);
      cyc++;
      if (!inflight) begin
        if (start_next) begin
          if (mq.size() == 0) begin
            chk("model_start_empty", 32'd1, 32'd0);
          end else begin
            cur = mq.pop_front();
            inflight  = 1'b1;
            att       = 0;
            gap_left  = 0;
            start_cyc = cyc;
          end
          start_next = 1'b0;
        end else begin
          start_next = (mq.size() > 0);
        end
      end
      qsize    = mq.size();
      in_issue = inflight && (exp_q.size() == 0) && (gap_left == 0);
      in_gap   = inflight && (exp_q.size() == 0) && (gap_left > 0);

      chk("cfg_valid", 32'(cfg_valid_o), 32'(in_issue));
      if (in_issue && cfg_valid_o) begin
        chk("cfg_addr", 32'(cfg_addr_o), 32'(cur.addr));
        chk("cfg_rwn", 32'(cfg_rwn_o), (cur.op == 0) ? 32'd0 : 32'd1);
        if (cur.op == 0) chk("cfg_wdata", cfg_data_o, cur.data);
      end
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0 && rsp_valid_o) begin
        chk("rsp_data", rsp_data_o, exp_q[0][31:0]);
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_q[0][32]));
      end
      chk("cmd_ready", 32'(cmd_ready_o), 32'(qsize < DEPTH));
      chk("busy", 32'(busy_o), 32'((qsize > 0) || inflight));

      if (cfg_valid_o) valid_hi_cnt++;
      if (cfg_valid_o && !prev_valid) rise_cyc = cyc;
      if (rsp_valid_o && !prev_rsp) rsp_rise_cyc = cyc;
      prev_valid = cfg_valid_o;
      prev_rsp   = rsp_valid_o;

      // advance the model by what happens at the coming edge
      rsp_done = (exp_q.size() > 0) && rsp_ready_i;
      if (in_gap) gap_left--;
      if (in_issue && cfg_ready_i) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        sample = cfg_data_i;
        fin = 1'b1;
        err = 1'b0;
        if (cur.op == 0) begin
          sample = 32'h0;
        end else if (cur.op == 2) begin
          att++;
          if (((sample ^ cur.data) & cur.mask) == 32'h0) fin = 1'b1;
          else if (att == MAX_TRIES) err = 1'b1;
          else begin
            fin = 1'b0;
            gap_left = GAP_EFF;
          end
        end
        if (fin) exp_q.push_back({err, sample});
      end
      if (rsp_done) begin
        void'(exp_q.pop_front());
        inflight = 1'b0;
        rsp_cnt++;
        last_rsp_data = rsp_data_o;
        last_rsp_err  = rsp_err_o;
      end
      if (cmd_valid_i && (qsize < DEPTH)) begin
        mcmd_t c;
        c.op   = (cmd_op_i == 2'd3) ? 1 : int'(cmd_op_i);
        c.addr = cmd_addr_i;
        c.data = cmd_data_i;
        c.mask = cmd_mask_i;
        mq.push_back(c);
        push_cyc = cyc;
      end
      if (rst_i) begin
        mq.delete();
        exp_q.delete();
        inflight   = 1'b0;
        start_next = 1'b0;
        gap_left   = 0;
        att        = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] op, input logic [4:0] addr,
                      input logic [31:0] data, input logic [31:0] mask);
    bit acc = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    cmd_mask_i  = mask;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready_o;
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_quiet(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = !busy_o;
    end
    if (!done) chk("quiet_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data_o, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err_o), 32'd0);
    chk({tag, "_cfg_valid"}, 32'(cfg_valid_o), 32'd0);
    chk({tag, "_cfg_addr"},  32'(cfg_addr_o), 32'd0);
    chk({tag, "_cfg_data"},  cfg_data_o, 32'd0);
    chk({tag, "_cfg_rwn"},   32'(cfg_rwn_o), 32'd1);
    chk({tag, "_busy"},      32'(busy_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, h0, r0;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = '0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    cmd_mask_i  = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // WRITE: single cfg cycle, zero response data, N+2 / N+3 latency
    rdy_mode = 0; dat_mode = 0; dat_const = 32'hDEAD_BEEF; rrdy_force = 1'b1;
    v0 = valid_hi_cnt;
    push(2'd0, 5'h01, 32'h0000_0100, 32'h0);
    wait_quiet(100);
    chk("wr_valid_cycles", 32'(valid_hi_cnt - v0), 32'd1);
    chk("wr_rsp_data", last_rsp_data, 32'h0);
    chk("wr_rsp_err", 32'(last_rsp_err), 32'd0);
    chk("wr_cfg_latency", 32'(rise_cyc - push_cyc), 32'd2);
    chk("wr_rsp_latency", 32'(rsp_rise_cyc - push_cyc), 32'd3);

    // READ with cfg_ready low for three cycles
    v_base = vcnt; rdy_mode = 3; dat_const = 32'h15;
    v0 = valid_hi_cnt;
    push(2'd1, 5'h02, 32'h0, 32'h0);
    wait_quiet(100);
    chk("rd_rsp_data", last_rsp_data, 32'h15);
    chk("rd_valid_cycles", 32'(valid_hi_cnt - v0), 32'd4);

    // POLL that succeeds on the third read
    rdy_mode = 0; dat_mode = 1; rd_base = rd_cnt; clear_after = 2;
    h0 = hs_cnt;
    push(2'd2, 5'h02, 32'h0, 32'h20);
    wait_quiet(400);
    chk("poll_reads", 32'(hs_cnt - h0), 32'd3);
    chk("poll_span", 32'(last_hs_cyc - start_cyc), 32'(2 * (GAP_EFF + 1)));
    chk("poll_err", 32'(last_rsp_err), 32'd0);
    chk("poll_data", last_rsp_data, 32'h0);

    // POLL that never matches
    rd_base = rd_cnt; clear_after = 1000;
    h0 = hs_cnt;
    push(2'd2, 5'h02, 32'h0, 32'h20);
    wait_quiet(1000);
    chk("poll_to_reads", 32'(hs_cnt - h0), 32'd16);
    chk("poll_to_span", 32'(last_hs_cyc - start_cyc), 32'(15 * (GAP_EFF + 1)));
    chk("poll_to_err", 32'(last_rsp_err), 32'd1);
    chk("poll_to_data", last_rsp_data, 32'h20);

    // Reserved op executes as READ
    dat_mode = 3;
    push(2'd3, 5'h07, 32'h1234_5678, 32'h0);
    wait_quiet(100);
    chk("op3_rsp_data", last_rsp_data, 32'hA5A5_0007);

    // Back-pressure: responses stalled, FIFO fills
    rrdy_force = 1'b0;
    r0 = rsp_cnt;
    for (int i = 0; i < 5; i++) push(2'd1, 5'(10 + i), 32'h0, 32'h0);
    @(negedge clk);
    chk("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    fork
      push(2'd1, 5'd15, 32'h0, 32'h0);
      begin
        repeat (4) @(posedge clk);
        #1 rrdy_force = 1'b1;
      end
    join
    wait_quiet(200);
    chk("bp_rsp_count", 32'(rsp_cnt - r0), 32'd6);
    chk("bp_last_data", last_rsp_data, 32'hA5A5_000F);

    // Randomized traffic
    rrdy_rand = 1'b1; rdy_mode = 1; dat_mode = 2;
    r0 = rsp_cnt;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'd2)
        push(op, 5'($urandom_range(0, 31)), 32'($urandom_range(0, 7)), 32'($urandom_range(1, 7)));
      else
        push(op, 5'($urandom_range(0, 31)), $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_quiet(6000);
    chk("rand_rsp_count", 32'(rsp_cnt - r0), 32'd60);
    rrdy_rand = 1'b0; rrdy_force = 1'b1; rdy_mode = 0;

    // Reset mid-transaction with two commands queued
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) push(2'd0, 5'(20 + i), 32'(i + 1), 32'h0);
    @(negedge clk);
    chk("mid_cfg_valid", 32'(cfg_valid_o), 32'd1);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rdy_mode = 0;
    h0 = hs_cnt;
    v0 = valid_hi_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_hs", 32'(hs_cnt - h0), 32'd0);
    chk("midrst_no_valid", 32'(valid_hi_cnt - v0), 32'd0);
    chk("model_queue_empty", 32'(mq.size() + exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #(400000);
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
